hr_bridge16: RTL and testbench
==============================

Name: hr_bridge16

Overview:
- Bridge between one local ring and the global ring of a 16-node hierarchical-ring NoC: four nodes per local ring, four local rings.
- Each ring has two lanes (0 and 1).
- Flits passing through the bridge are either forwarded along their ring or ejected into external transfer FIFOs toward the other ring.
- Heads of the transfer FIFOs are injected into free ring slots.

Parameters:
- RING_ID, 2'd0, index of the local ring this bridge serves. Matches destination bits [3:2].

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- port_l0_i, port_l1_i  in  144  flit arriving on local lane 0/1.
- port_g0_i, port_g1_i  in  144  flit arriving on global lane 0/1.
- port_l0_o, port_l1_o  out  144  flit leaving on local lane 0/1.
- port_g0_o, port_g1_o  out  144  flit leaving on global lane 0/1.
- FIFO_l0_i, FIFO_l1_i  in  144  head of global-to-local FIFO for local lane k. Injected onto the local ring.
- FIFO_g0_i, FIFO_g1_i  in  144  head of local-to-global FIFO for global lane k. Injected onto the global ring.
- FIFO_l0_o, FIFO_l1_o  out  144  flit written into the global-to-local FIFO k.
- FIFO_g0_o, FIFO_g1_o  out  144  flit written into the local-to-global FIFO k.
- bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i  in  1  the matching FIFO (written via FIFO_*_o) is full.
- deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o  out  1  pop the head of FIFO_*_i (head consumed this cycle).
- enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o  out  1  push FIFO_*_o.

Behaviour:
- Flit format (144 bits):
  - [143:16] payload.
  - [15:13] reserved, passed unchanged.
  - [12] valid.
  - [11:8] type/seq, passed unchanged.
  - [7:4] src node.
  - [3:0] dst node; dst ring = dst[3:2].
- A flit with valid=0 is an empty slot.
- All 16 outputs are registered, with exactly 1 cycle latency from inputs to outputs.
- Reset (rst=0, asynchronous):
  - all port_*_o and FIFO_*_o = 144'h0;
  - all deQ/enQ = 0.
  - Reset takes effect immediately mid-operation; in-flight flits are dropped.
- Local lane k, evaluated independently each cycle (l-lanes and g-lanes have no cross-lane interaction except via index k):
  - Eject: if port_lk_i valid, dst[3:2] != RING_ID and bfull_gk_i=0, then FIFO_gk_o <= port_lk_i and enQ_gk_o <= 1. The slot becomes free.
  - Blocked ejection: if an off-ring flit finds bfull_gk_i=1, it stays on the local ring (port_lk_o <= port_lk_i).
  - On-ring flits always pass through to port_lk_o.
  - Inject: if the local slot is free (empty input or just ejected) and FIFO_lk_i valid, then port_lk_o <= FIFO_lk_i and deQ_lk_o <= 1.
  - Otherwise port_lk_o <= 0 (if empty) or the passing flit, and deQ_lk_o <= 0.
- Global lane k, same rule with roles swapped:
  - Eject: if port_gk_i valid, dst[3:2] == RING_ID and bfull_lk_i=0, then FIFO_lk_o <= port_gk_i and enQ_lk_o <= 1. Otherwise the flit passes to port_gk_o.
  - Inject: a free global slot takes FIFO_gk_i if valid, asserting deQ_gk_o.
- When enQ is 0, the corresponding FIFO_*_o is driven 144'h0.
- Ejection and injection on the same lane in the same cycle are allowed: the slot is reused.
- Ring traffic has priority over injection. A FIFO head never displaces a valid passing flit.
- bfull is sampled in the same cycle as the decision. enQ is never asserted while the matching bfull=1.
- deQ is asserted only when the FIFO head is valid.

Test Plan:
- Reset: drive rst=0 with arbitrary inputs, then release -> every output is 0 until the first clk edge after release.
- Full FIFOs, all slots occupied (RING_ID=0): port_l0_i=...1855, port_l1_i=...185f, port_g0_i=...1851, port_g1_i=...1853, all bfull=1, all FIFO heads valid -> after one edge each port_*_o equals its input, all enQ=0, all deQ=0, all FIFO_*_o=0.
- Local ejection: port_l0_i=...1855 (dst ring 1), bfull_g0_i=0, FIFO_l0_i=...1854 -> FIFO_g0_o=...1855, enQ_g0_o=1, port_l0_o=...1854, deQ_l0_o=1.
- Global ejection: port_g0_i valid with dst=4'h2, bfull_l0_i=0 -> FIFO_l0_o=flit, enQ_l0_o=1. With bfull_l0_i=1 instead -> port_g0_o=flit, enQ_l0_o=0.
- Empty-slot injection: all ports 0, FIFO_g1_i=...1851 valid -> port_g1_o=...1851, deQ_g1_o=1. Invalid FIFO heads -> outputs 0, deQ=0.
- Idle: all inputs 0 -> all outputs 0 on every cycle.

Source files
------------

// File: rtl/hr_bridge16_if.sv
// Bus bundle for the hierarchical-ring bridge: ring lanes, transfer-FIFO heads/writes and their handshakes.
// The master modport is the bridge itself; the slave modport is the surrounding rings and FIFOs.
interface hr_bridge16_if;
    logic [143:0] port_l0_i, port_l1_i, port_g0_i, port_g1_i;
    logic [143:0] port_l0_o, port_l1_o, port_g0_o, port_g1_o;
    logic [143:0] FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i;
    logic [143:0] FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o;
    logic         bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i;
    logic         deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o;
    logic         enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o;

    modport master (
        input  port_l0_i, port_l1_i, port_g0_i, port_g1_i,
        output port_l0_o, port_l1_o, port_g0_o, port_g1_o,
        input  FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i,
        output FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o,
        input  bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i,
        output deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o,
        output enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o
    );

    modport slave (
        output port_l0_i, port_l1_i, port_g0_i, port_g1_i,
        input  port_l0_o, port_l1_o, port_g0_o, port_g1_o,
        output FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i,
        input  FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o,
        output bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i,
        input  deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o,
        input  enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o
    );
endinterface

// File: rtl/hr_bridge16.sv
// Local/global ring bridge for a 16-node hierarchical ring: per lane, eject flits bound for the
// other ring into its transfer FIFO and inject transfer-FIFO heads into free slots. All outputs registered.
module hr_bridge16 #(
    parameter logic [1:0] RING_ID = 2'd0
) (
    input  logic           clk,
    input  logic           rst,
    hr_bridge16_if.master  bus
);
    // Lane index map: 0 = local lane 0, 1 = local lane 1, 2 = global lane 0, 3 = global lane 1.
    logic [143:0] ring_in    [4];
    logic [143:0] fifo_head  [4];
    logic         bfull      [4];
    logic [143:0] eject_flit [4];
    logic         eject_vld  [4];
    logic [143:0] port_next  [4];
    logic         deq_next   [4];

    logic [143:0] port_out_reg [4];
    logic [143:0] fifo_out_reg [4];
    logic         deq_reg      [4];
    logic         enq_reg      [4];

    assign ring_in[0]   = bus.port_l0_i;
    assign ring_in[1]   = bus.port_l1_i;
    assign ring_in[2]   = bus.port_g0_i;
    assign ring_in[3]   = bus.port_g1_i;
    assign fifo_head[0] = bus.FIFO_l0_i;
    assign fifo_head[1] = bus.FIFO_l1_i;
    assign fifo_head[2] = bus.FIFO_g0_i;
    assign fifo_head[3] = bus.FIFO_g1_i;
    assign bfull[0]     = bus.bfull_l0_i;
    assign bfull[1]     = bus.bfull_l1_i;
    assign bfull[2]     = bus.bfull_g0_i;
    assign bfull[3]     = bus.bfull_g1_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            // A lane's ejections land in the FIFO feeding the same-numbered lane of the other ring.
            localparam int  XFER     = gi ^ 2;
            localparam bit  IS_LOCAL = (gi < 2);

            logic on_this_ring;
            logic wants_exit;
            logic eject;
            logic slot_busy;
            logic inject;

            assign on_this_ring = (ring_in[gi][3:2] == RING_ID);
            assign wants_exit   = IS_LOCAL ? !on_this_ring : on_this_ring;
            assign eject        = ring_in[gi][12] && wants_exit && !bfull[XFER];
            // Ring traffic keeps its slot; only an empty or just-ejected slot accepts a FIFO head.
            assign slot_busy    = ring_in[gi][12] && !eject;
            assign inject       = !slot_busy && fifo_head[gi][12];

            assign eject_vld[gi]  = eject;
            assign eject_flit[gi] = eject ? ring_in[gi] : 144'h0;
            assign deq_next[gi]   = inject;
            assign port_next[gi]  = slot_busy ? ring_in[gi] :
                                    inject    ? fifo_head[gi] : 144'h0;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    port_out_reg[gi] <= 144'h0;
                    fifo_out_reg[gi] <= 144'h0;
                    deq_reg[gi]      <= 1'b0;
                    enq_reg[gi]      <= 1'b0;
                end else begin
                    port_out_reg[gi] <= port_next[gi];
                    fifo_out_reg[gi] <= eject_flit[XFER];
                    deq_reg[gi]      <= deq_next[gi];
                    enq_reg[gi]      <= eject_vld[XFER];
                end
            end
        end
    endgenerate

    assign bus.port_l0_o = port_out_reg[0];
    assign bus.port_l1_o = port_out_reg[1];
    assign bus.port_g0_o = port_out_reg[2];
    assign bus.port_g1_o = port_out_reg[3];
    assign bus.FIFO_l0_o = fifo_out_reg[0];
    assign bus.FIFO_l1_o = fifo_out_reg[1];
    assign bus.FIFO_g0_o = fifo_out_reg[2];
    assign bus.FIFO_g1_o = fifo_out_reg[3];
    assign bus.deQ_l0_o  = deq_reg[0];
    assign bus.deQ_l1_o  = deq_reg[1];
    assign bus.deQ_g0_o  = deq_reg[2];
    assign bus.deQ_g1_o  = deq_reg[3];
    assign bus.enQ_l0_o  = enq_reg[0];
    assign bus.enQ_l1_o  = enq_reg[1];
    assign bus.enQ_g0_o  = enq_reg[2];
    assign bus.enQ_g1_o  = enq_reg[3];
endmodule

// File: tb/tb_hr_bridge16.sv
// Self-checking bench for hr_bridge16 (RING_ID = 0): directed scenarios plus randomized traffic
// checked against a per-lane behavioural model of the forwarding/ejection/injection rules.
module tb_hr_bridge16;
    localparam logic [1:0] RING = 2'd0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hr_bridge16_if bus ();
    hr_bridge16 #(.RING_ID(RING)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Index map: 0 = l0, 1 = l1, 2 = g0, 3 = g1.
    logic [143:0] in_port [4];
    logic [143:0] in_head [4];
    logic         in_bfull [4];
    logic [143:0] obs_port [4];
    logic [143:0] obs_fifo [4];
    logic         obs_deq [4];
    logic         obs_enq [4];
    logic [143:0] exp_port [4];
    logic [143:0] exp_fifo [4];
    logic         exp_deq [4];
    logic         exp_enq [4];
    string        lane_name [4] = '{"l0", "l1", "g0", "g1"};

    function automatic logic [143:0] mk(input logic [15:0] lo);
        logic [127:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        return {p, lo};
    endfunction

    function automatic logic [143:0] rand_flit();
        logic [15:0] lo;
        lo = 16'($urandom);
        lo[12] = ($urandom_range(0, 9) < 7);
        return mk(lo);
    endfunction

    task automatic drive();
        bus.port_l0_i = in_port[0];  bus.port_l1_i = in_port[1];
        bus.port_g0_i = in_port[2];  bus.port_g1_i = in_port[3];
        bus.FIFO_l0_i = in_head[0];  bus.FIFO_l1_i = in_head[1];
        bus.FIFO_g0_i = in_head[2];  bus.FIFO_g1_i = in_head[3];
        bus.bfull_l0_i = in_bfull[0]; bus.bfull_l1_i = in_bfull[1];
        bus.bfull_g0_i = in_bfull[2]; bus.bfull_g1_i = in_bfull[3];
    endtask

    task automatic sample();
        obs_port[0] = bus.port_l0_o; obs_port[1] = bus.port_l1_o;
        obs_port[2] = bus.port_g0_o; obs_port[3] = bus.port_g1_o;
        obs_fifo[0] = bus.FIFO_l0_o; obs_fifo[1] = bus.FIFO_l1_o;
        obs_fifo[2] = bus.FIFO_g0_o; obs_fifo[3] = bus.FIFO_g1_o;
        obs_deq[0] = bus.deQ_l0_o; obs_deq[1] = bus.deQ_l1_o;
        obs_deq[2] = bus.deQ_g0_o; obs_deq[3] = bus.deQ_g1_o;
        obs_enq[0] = bus.enQ_l0_o; obs_enq[1] = bus.enQ_l1_o;
        obs_enq[2] = bus.enQ_g0_o; obs_enq[3] = bus.enQ_g1_o;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            in_port[i] = '0; in_head[i] = '0; in_bfull[i] = 1'b0;
            exp_port[i] = '0; exp_fifo[i] = '0; exp_deq[i] = 1'b0; exp_enq[i] = 1'b0;
        end
    endtask

    // Reference: a flit leaves its ring when bound for the other ring and that ring's FIFO has room;
    // whatever stays keeps the slot, otherwise a valid FIFO head takes the freed slot.
    task automatic model();
        for (int i = 0; i < 4; i++) begin
            exp_fifo[i] = '0; exp_enq[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            bit is_local, dest_here, leaves;
            int other;
            is_local  = (i < 2);
            other     = is_local ? i + 2 : i - 2;
            dest_here = (in_port[i][3:2] == RING);
            leaves    = in_port[i][12] && (is_local != dest_here) && !in_bfull[other];
            if (leaves) begin
                exp_fifo[other] = in_port[i];
                exp_enq[other]  = 1'b1;
            end
            if (in_port[i][12] && !leaves) begin
                exp_port[i] = in_port[i]; exp_deq[i] = 1'b0;
            end else if (in_head[i][12]) begin
                exp_port[i] = in_head[i]; exp_deq[i] = 1'b1;
            end else begin
                exp_port[i] = '0; exp_deq[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_port[i] = rand_flit(); in_head[i] = rand_flit(); in_bfull[i] = 1'($urandom);
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        sample();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_port[i] !== 144'h0 || obs_fifo[i] !== 144'h0 || obs_deq[i] !== 1'b0 || obs_enq[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset lane %s: port=%h fifo=%h deq=%b enq=%b, required all zero",
                         lane_name[i], obs_port[i], obs_fifo[i], obs_deq[i], obs_enq[i]);
            end
        end
        $display("txn reset: outputs held at zero after release, errors so far %0d", errors);
        @(posedge clk); #1;
    endtask

    task automatic test_full_fifos();
        clear_all();
        in_port[0] = mk(16'h1855); in_port[1] = mk(16'h185f);
        in_port[2] = mk(16'h1851); in_port[3] = mk(16'h1853);
        for (int i = 0; i < 4; i++) begin
            in_head[i] = mk(16'h1000 | 16'(i)); in_bfull[i] = 1'b1; exp_port[i] = in_port[i];
        end
        drive();
        @(posedge clk); #1;
        sample();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_port[i] !== exp_port[i] || obs_fifo[i] !== 144'h0 || obs_deq[i] !== 1'b0 || obs_enq[i] !== 1'b0) begin
                errors++;
                $display("FAIL full_fifos lane %s: port=%h fifo=%h deq=%b enq=%b, required port=%h fifo=0 deq=0 enq=0",
                         lane_name[i], obs_port[i], obs_fifo[i], obs_deq[i], obs_enq[i], exp_port[i]);
            end
        end
        $display("txn full_fifos: errors so far %0d", errors);
    endtask

    task automatic test_local_eject();
        clear_all();
        in_port[0] = mk(16'h1855); in_head[0] = mk(16'h1854);
        exp_fifo[2] = in_port[0]; exp_enq[2] = 1'b1;
        exp_port[0] = in_head[0]; exp_deq[0] = 1'b1;
        drive();
        @(posedge clk); #1;
        sample();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_port[i] !== exp_port[i] || obs_fifo[i] !== exp_fifo[i] || obs_deq[i] !== exp_deq[i] || obs_enq[i] !== exp_enq[i]) begin
                errors++;
                $display("FAIL local_eject lane %s: port=%h fifo=%h deq=%b enq=%b, required port=%h fifo=%h deq=%b enq=%b",
                         lane_name[i], obs_port[i], obs_fifo[i], obs_deq[i], obs_enq[i],
                         exp_port[i], exp_fifo[i], exp_deq[i], exp_enq[i]);
            end
        end
        $display("txn local_eject: errors so far %0d", errors);
    endtask

    task automatic test_global_eject();
        for (int pass = 0; pass < 2; pass++) begin
            clear_all();
            in_port[2]  = mk(16'h1002);
            in_bfull[0] = (pass == 1);
            if (pass == 0) begin
                exp_fifo[0] = in_port[2]; exp_enq[0] = 1'b1;
            end else begin
                exp_port[2] = in_port[2];
            end
            drive();
            @(posedge clk); #1;
            sample();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_port[i] !== exp_port[i] || obs_fifo[i] !== exp_fifo[i] || obs_deq[i] !== exp_deq[i] || obs_enq[i] !== exp_enq[i]) begin
                    errors++;
                    $display("FAIL global_eject bfull=%0d lane %s: port=%h fifo=%h deq=%b enq=%b, required port=%h fifo=%h deq=%b enq=%b",
                             pass, lane_name[i], obs_port[i], obs_fifo[i], obs_deq[i], obs_enq[i],
                             exp_port[i], exp_fifo[i], exp_deq[i], exp_enq[i]);
                end
            end
            $display("txn global_eject bfull_l0=%0d: errors so far %0d", pass, errors);
        end
    endtask

    task automatic test_empty_inject();
        for (int pass = 0; pass < 2; pass++) begin
            clear_all();
            if (pass == 0) begin
                in_head[3] = mk(16'h1851); exp_port[3] = in_head[3]; exp_deq[3] = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) in_head[i] = mk(16'h0851);
            end
            drive();
            @(posedge clk); #1;
            sample();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_port[i] !== exp_port[i] || obs_fifo[i] !== exp_fifo[i] || obs_deq[i] !== exp_deq[i] || obs_enq[i] !== exp_enq[i]) begin
                    errors++;
                    $display("FAIL empty_inject case%0d lane %s: port=%h deq=%b fifo=%h enq=%b, required port=%h deq=%b fifo=%h enq=%b",
                             pass, lane_name[i], obs_port[i], obs_deq[i], obs_fifo[i], obs_enq[i],
                             exp_port[i], exp_deq[i], exp_fifo[i], exp_enq[i]);
                end
            end
            $display("txn empty_inject case%0d: errors so far %0d", pass, errors);
        end
    endtask

    task automatic test_idle();
        clear_all();
        drive();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            sample();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_port[i] !== 144'h0 || obs_fifo[i] !== 144'h0 || obs_deq[i] !== 1'b0 || obs_enq[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle cycle %0d lane %s: port=%h fifo=%h deq=%b enq=%b, required all zero",
                             c, lane_name[i], obs_port[i], obs_fifo[i], obs_deq[i], obs_enq[i]);
                end
            end
            $display("txn idle cycle %0d: errors so far %0d", c, errors);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) begin
                in_port[i]  = rand_flit();
                in_head[i]  = rand_flit();
                in_bfull[i] = 1'($urandom);
            end
            drive();
            model();
            @(posedge clk); #1;
            sample();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_port[i] !== exp_port[i]) begin
                    errors++;
                    $display("FAIL random t=%0d port_%s_o got %h required %h", t, lane_name[i], obs_port[i], exp_port[i]);
                end
                checks++;
                if (obs_fifo[i] !== exp_fifo[i] || obs_enq[i] !== exp_enq[i]) begin
                    errors++;
                    $display("FAIL random t=%0d FIFO_%s_o/enQ got %h/%b required %h/%b", t, lane_name[i],
                             obs_fifo[i], obs_enq[i], exp_fifo[i], exp_enq[i]);
                end
                checks++;
                if (obs_deq[i] !== exp_deq[i]) begin
                    errors++;
                    $display("FAIL random t=%0d deQ_%s_o got %b required %b", t, lane_name[i], obs_deq[i], exp_deq[i]);
                end
            end
            $display("txn random %0d: errors so far %0d", t, errors);
        end
    endtask

    task automatic test_async_reset();
        // Load busy traffic, then pull reset between edges: outputs must clear without a clock.
        clear_all();
        for (int i = 0; i < 4; i++) begin
            in_port[i] = mk(16'h1000 | 16'(i)); in_bfull[i] = 1'b1;
        end
        drive();
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        sample();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_port[i] !== 144'h0 || obs_fifo[i] !== 144'h0 || obs_deq[i] !== 1'b0 || obs_enq[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset lane %s: port=%h fifo=%h deq=%b enq=%b, required all zero",
                         lane_name[i], obs_port[i], obs_fifo[i], obs_deq[i], obs_enq[i]);
            end
        end
        $display("txn async_reset: errors so far %0d", errors);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        clear_all();
        drive();
        test_reset();
        test_full_fifos();
        test_local_eject();
        test_global_eject();
        test_empty_inject();
        test_idle();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
